// File: rtl/apb_mailbox_pkg.sv
// -----------------------------------------------------------------------------
// apb_mailbox_pkg
//   Shared definitions for the APB mailbox completer: register word indices
//   (PADDR[4:2]), bit positions inside STATUS/CTRL/INTSTAT, the bus-side FSM
//   state type and a count saturation helper.
// -----------------------------------------------------------------------------
package apb_mailbox_pkg;

    // Register word indices (PADDR[4:2])
    localparam logic [2:0] REG_TXDATA  = 3'd0;
    localparam logic [2:0] REG_RXDATA  = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_CTRL    = 3'd3;
    localparam logic [2:0] REG_THRESH  = 3'd4;
    localparam logic [2:0] REG_INTSTAT = 3'd5;

    // STATUS flag bits (counts live in [15:8] and [23:16])
    localparam int ST_TXFULL  = 0;
    localparam int ST_TXEMPTY = 1;
    localparam int ST_RXFULL  = 2;
    localparam int ST_RXEMPTY = 3;

    // CTRL bits
    localparam int CTRL_RX_IE    = 0;
    localparam int CTRL_TX_IE    = 1;
    localparam int CTRL_TXFLUSH  = 2;
    localparam int CTRL_RXFLUSH  = 3;

    // INTSTAT bits
    localparam int INT_TX_OVF = 0;
    localparam int INT_RX_UNF = 1;

    // Bus-side FSM. The setup phase is the IDLE cycle that sees
    // PSEL & !PENABLE; the state register then moves to ACCESS so that the
    // very next cycle (first access-phase cycle) can already complete.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_t;

    // A full 256-entry FIFO holds 256, which does not fit the 8-bit field.
    function automatic logic [7:0] sat8(input logic [8:0] cnt);
        return cnt[8] ? 8'hFF : cnt[7:0];
    endfunction

endpackage

// File: rtl/apb_mailbox_fifo.sv
// -----------------------------------------------------------------------------
// apb_mailbox_fifo
//   Synchronous show-ahead FIFO: rdata always shows the head entry.
//   Pointers carry one extra bit so full/empty/count never alias.
//   flush has priority over push and pop in the same cycle; push while full
//   and pop while empty are ignored.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   push, wdata   write request and data
//   pop           remove head entry
//   flush         empty the FIFO
//   rdata         head entry (undefined content when empty)
//   full, empty   status flags
//   count         number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module apb_mailbox_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush && !rst;
    assign do_pop  = pop && !empty && !flush && !rst;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: the storage array has no reset; empty/count come from the
    // pointers, so stale contents are never observable and the array can map
    // to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/apb_mailbox_slave.sv
// -----------------------------------------------------------------------------
// apb_mailbox_slave
//   APB3 completer with a TX FIFO (APB writes -> local valid/ready consumer)
//   and an RX FIFO (local producer -> APB reads), plus a registered level IRQ
//   built from FIFO thresholds and sticky error flags.
//   Only PADDR[4:2] is decoded; index 6 and 7 are unmapped.
// Build option
//   APB_MAILBOX_SLVERR_EN  when defined, PSLVERR flags TXDATA write while full,
//                          RXDATA read while empty, and unmapped accesses.
//                          When undefined PSLVERR is tied low.
// Ports
//   PCLK, PRESET           clock, synchronous active-high reset
//   PSEL..PWDATA           APB3 request
//   PRDATA, PREADY, PSLVERR APB3 response
//   TX_DATA/VALID/READY    TX FIFO head towards the local consumer
//   RX_DATA/VALID/READY    local producer into the RX FIFO
//   IRQ                    registered level interrupt
// -----------------------------------------------------------------------------
module apb_mailbox_slave
    import apb_mailbox_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    input  logic [DATA_W-1:0] RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic              IRQ
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    apb_state_t state, next_state;
    logic [3:0] wait_cnt, next_wait_cnt;

    logic [2:0] reg_idx;
    logic       complete, wr_en, rd_en;
    logic       tx_push_req, tx_ovf_evt, rx_pop_req, rx_unf_evt;

    logic              rx_ie, tx_ie, tx_flush, rx_flush;
    logic [7:0]        rx_th, tx_th;
    logic              tx_ovf, rx_unf;
    logic              irq_q, irq_next;

    logic [DATA_W-1:0] tx_head, rx_head, rdata_mux;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [AW:0]       tx_count, rx_count;
    logic [8:0]        tx_cnt9, rx_cnt9;

    logic unused_paddr;
    assign unused_paddr = ^{PADDR[ADDR_W-1:5], PADDR[1:0]};

    // ---------------- bus FSM ----------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait_cnt;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a variable unassigned (which would infer a latch).
    always_comb begin
        next_state    = state;
        next_wait_cnt = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    next_state    = ST_ACCESS;
                    next_wait_cnt = WAIT_INIT;
                end
            end
            ST_ACCESS: begin
                // PSEL dropping aborts; counter at zero means this cycle completes.
                if (!PSEL || wait_cnt == '0) next_state = ST_IDLE;
                else                         next_wait_cnt = wait_cnt - 4'd1;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign PREADY   = (WAIT_STATES == 0) ? 1'b1
                    : (!PRESET && state == ST_ACCESS && wait_cnt == '0);
    // Reset wins over an in-flight access: no side effect on the reset cycle.
    assign complete = !PRESET && PSEL && PENABLE && PREADY && (state == ST_ACCESS);
    assign wr_en    = complete && PWRITE;
    assign rd_en    = complete && !PWRITE;
    assign reg_idx  = PADDR[4:2];

    assign tx_push_req = wr_en && (reg_idx == REG_TXDATA);
    assign tx_ovf_evt  = tx_push_req && tx_full;
    assign rx_pop_req  = rd_en && (reg_idx == REG_RXDATA);
    assign rx_unf_evt  = rx_pop_req && rx_empty;

    // ---------------- FIFOs ----------------
    apb_mailbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (tx_push_req),
        .wdata (PWDATA),
        .pop   (TX_VALID && TX_READY),
        .flush (tx_flush),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    apb_mailbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (RX_VALID && RX_READY),
        .wdata (RX_DATA),
        .pop   (rx_pop_req),
        .flush (rx_flush),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign TX_DATA  = tx_head;
    assign TX_VALID = !tx_empty && !PRESET;
    assign RX_READY = !rx_full || PRESET;
    assign tx_cnt9  = 9'(tx_count);
    assign rx_cnt9  = 9'(rx_count);

    // ---------------- control / status registers ----------------
    assign irq_next = (rx_ie && rx_th != 8'd0 && rx_cnt9 >= {1'b0, rx_th})
                    || (tx_ie && tx_cnt9 <= {1'b0, tx_th})
                    || tx_ovf || rx_unf;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_ie    <= 1'b0;
            tx_ie    <= 1'b0;
            tx_flush <= 1'b0;
            rx_flush <= 1'b0;
            rx_th    <= '0;
            tx_th    <= '0;
            tx_ovf   <= 1'b0;
            rx_unf   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            // Flush bits are one-cycle pulses unless rewritten this cycle.
            tx_flush <= 1'b0;
            rx_flush <= 1'b0;
            if (wr_en && reg_idx == REG_CTRL) begin
                rx_ie    <= PWDATA[CTRL_RX_IE];
                tx_ie    <= PWDATA[CTRL_TX_IE];
                tx_flush <= PWDATA[CTRL_TXFLUSH];
                rx_flush <= PWDATA[CTRL_RXFLUSH];
            end
            if (wr_en && reg_idx == REG_THRESH) begin
                rx_th <= PWDATA[7:0];
                tx_th <= PWDATA[15:8];
            end
            if (tx_ovf_evt)
                tx_ovf <= 1'b1;
            else if (wr_en && reg_idx == REG_INTSTAT && PWDATA[INT_TX_OVF])
                tx_ovf <= 1'b0;
            if (rx_unf_evt)
                rx_unf <= 1'b1;
            else if (wr_en && reg_idx == REG_INTSTAT && PWDATA[INT_RX_UNF])
                rx_unf <= 1'b0;
            irq_q <= irq_next;
        end
    end

    assign IRQ = irq_q;

    // ---------------- read path ----------------
    always_comb begin
        rdata_mux = '0;
        case (reg_idx)
            REG_RXDATA: if (!rx_empty) rdata_mux = rx_head;
            REG_STATUS: begin
                rdata_mux[ST_TXFULL]  = tx_full;
                rdata_mux[ST_TXEMPTY] = tx_empty;
                rdata_mux[ST_RXFULL]  = rx_full;
                rdata_mux[ST_RXEMPTY] = rx_empty;
                rdata_mux[15:8]       = sat8(tx_cnt9);
                rdata_mux[23:16]      = sat8(rx_cnt9);
            end
            REG_CTRL: begin
                rdata_mux[CTRL_RX_IE]   = rx_ie;
                rdata_mux[CTRL_TX_IE]   = tx_ie;
                rdata_mux[CTRL_TXFLUSH] = tx_flush;
                rdata_mux[CTRL_RXFLUSH] = rx_flush;
            end
            REG_THRESH: begin
                rdata_mux[7:0]  = rx_th;
                rdata_mux[15:8] = tx_th;
            end
            REG_INTSTAT: begin
                rdata_mux[INT_TX_OVF] = tx_ovf;
                rdata_mux[INT_RX_UNF] = rx_unf;
            end
            default: rdata_mux = '0;
        endcase
    end

    assign PRDATA = rd_en ? rdata_mux : '0;

`ifdef APB_MAILBOX_SLVERR_EN
    logic unmapped;
    assign unmapped = (reg_idx > REG_INTSTAT);
    assign PSLVERR  = tx_ovf_evt || rx_unf_evt || (complete && unmapped);
`else
    assign PSLVERR  = 1'b0;
`endif

endmodule

// File: tb/tb_apb_mailbox_slave.sv
module tb_apb_mailbox_slave;

    localparam logic [7:0] A_TXDATA  = 8'h00;
    localparam logic [7:0] A_RXDATA  = 8'h04;
    localparam logic [7:0] A_STATUS  = 8'h08;
    localparam logic [7:0] A_CTRL    = 8'h0C;
    localparam logic [7:0] A_THRESH  = 8'h10;
    localparam logic [7:0] A_INTSTAT = 8'h14;
    localparam logic [7:0] A_UNMAP   = 8'h18;

`ifdef APB_MAILBOX_SLVERR_EN
    localparam logic [31:0] SLVERR_EXP = 32'd1;
`else
    localparam logic [31:0] SLVERR_EXP = 32'd0;
`endif

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel0, psel3, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata0, prdata3, tx_data0, tx_data3, rx_data;
    logic        pready0, pready3, pslverr0, pslverr3;
    logic        tx_valid0, tx_valid3, tx_ready;
    logic        rx_valid0, rx_valid3, rx_ready0, rx_ready3;
    logic        irq0, irq3;

    int errors = 0;
    int checks = 0;

    always #5 pclk = ~pclk;

    apb_mailbox_slave #(.WAIT_STATES(0)) dut0 (
        .PCLK(pclk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0),
        .PREADY(pready0), .PSLVERR(pslverr0), .TX_DATA(tx_data0),
        .TX_VALID(tx_valid0), .TX_READY(tx_ready), .RX_DATA(rx_data),
        .RX_VALID(rx_valid0), .RX_READY(rx_ready0), .IRQ(irq0)
    );

    apb_mailbox_slave #(.WAIT_STATES(3)) dut3 (
        .PCLK(pclk), .PRESET(preset), .PSEL(psel3), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata3),
        .PREADY(pready3), .PSLVERR(pslverr3), .TX_DATA(tx_data3),
        .TX_VALID(tx_valid3), .TX_READY(tx_ready), .RX_DATA(rx_data),
        .RX_VALID(rx_valid3), .RX_READY(rx_ready3), .IRQ(irq3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One APB transfer on dut0 (use3=0) or dut3 (use3=1). Inputs change 1ns
    // after the rising edge; responses are sampled on the falling edge.
    task automatic apb(input bit use3, input bit wr, input logic [7:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic err, output int waits);
        logic rdy;
        @(posedge pclk); #1;
        psel0 = !use3; psel3 = use3; penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits = 0;
        @(negedge pclk);
        rdy = use3 ? pready3 : pready0;
        while (!rdy && waits < 40) begin
            waits++;
            @(negedge pclk);
            rdy = use3 ? pready3 : pready0;
        end
        check("pready", {31'd0, rdy}, 32'd1);
        rd  = use3 ? prdata3 : prdata0;
        err = use3 ? pslverr3 : pslverr0;
        @(posedge pclk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input bit use3, input logic [7:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic        e;
        int          w;
        apb(use3, 1'b1, a, d, r, e, w);
    endtask

    task automatic rd_chk(input bit use3, input string tag, input logic [7:0] a,
                          input logic [31:0] exp);
        logic [31:0] r;
        logic        e;
        int          w;
        apb(use3, 1'b0, a, 32'd0, r, e, w);
        check(tag, r, exp);
    endtask

    task automatic rx_push(input bit use3, input logic [31:0] d);
        @(posedge pclk); #1;
        rx_data = d;
        if (use3) rx_valid3 = 1'b1; else rx_valid0 = 1'b1;
        @(posedge pclk); #1;
        rx_valid0 = 1'b0; rx_valid3 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic        e;
        int          w;

        preset = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; tx_ready = 1'b0; rx_data = '0;
        rx_valid0 = 1'b0; rx_valid3 = 1'b0;
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;

        // Reset values
        @(negedge pclk);
        check("rst pready0",  {31'd0, pready0},   32'd1);
        check("rst pready3",  {31'd0, pready3},   32'd0);
        check("rst tx_valid", {31'd0, tx_valid0}, 32'd0);
        check("rst rx_ready", {31'd0, rx_ready0}, 32'd1);
        check("rst irq",      {31'd0, irq0},      32'd0);
        check("rst prdata",   prdata0,            32'd0);
        check("rst pslverr",  {31'd0, pslverr0},  32'd0);
        rd_chk(0, "status reset", A_STATUS, 32'h0000_000A);

        // Fill TX FIFO, consumer stalled
        for (int i = 1; i <= 16; i++) wr(0, A_TXDATA, 32'hA5A5_0000 + i);
        rd_chk(0, "status full", A_STATUS, 32'h0000_1009);
        check("tx head", tx_data0, 32'hA5A5_0001);

        // Overflow write
        apb(0, 1'b1, A_TXDATA, 32'hDEAD_BEEF, r, e, w);
        check("ovf pslverr", {31'd0, e}, SLVERR_EXP);
        check("ovf irq latency", {31'd0, irq0}, 32'd0);
        @(posedge pclk); #1;
        check("ovf irq", {31'd0, irq0}, 32'd1);
        rd_chk(0, "intstat ovf", A_INTSTAT, 32'h1);
        rd_chk(0, "status after drop", A_STATUS, 32'h0000_1009);
        check("tx head after drop", tx_data0, 32'hA5A5_0001);
        wr(0, A_INTSTAT, 32'h1);
        rd_chk(0, "intstat w1c", A_INTSTAT, 32'h0);
        check("irq after w1c", {31'd0, irq0}, 32'd0);

        // One local pop, then flush
        @(posedge pclk); #1 tx_ready = 1'b1;
        @(posedge pclk); #1 tx_ready = 1'b0;
        check("tx pop head", tx_data0, 32'hA5A5_0002);
        rd_chk(0, "status after pop", A_STATUS, 32'h0000_0F08);
        wr(0, A_CTRL, 32'h4);
        rd_chk(0, "ctrl flush selfclr", A_CTRL, 32'h0);
        rd_chk(0, "status after flush", A_STATUS, 32'h0000_000A);
        check("tx_valid after flush", {31'd0, tx_valid0}, 32'd0);

        // RX path and underflow
        rx_push(0, 32'h11);
        rx_push(0, 32'h22);
        rx_push(0, 32'h33);
        rd_chk(0, "rx status", A_STATUS, 32'h0003_0002);
        rd_chk(0, "rx pop 1", A_RXDATA, 32'h11);
        rd_chk(0, "rx pop 2", A_RXDATA, 32'h22);
        rd_chk(0, "rx pop 3", A_RXDATA, 32'h33);
        apb(0, 1'b0, A_RXDATA, 32'd0, r, e, w);
        check("rx unf data", r, 32'h0);
        check("rx unf pslverr", {31'd0, e}, SLVERR_EXP);
        rd_chk(0, "intstat unf", A_INTSTAT, 32'h2);
        check("irq unf", {31'd0, irq0}, 32'd1);
        wr(0, A_INTSTAT, 32'h2);
        rd_chk(0, "intstat unf w1c", A_INTSTAT, 32'h0);

        // Unmapped access
        apb(0, 1'b0, A_UNMAP, 32'd0, r, e, w);
        check("unmapped data", r, 32'h0);
        check("unmapped pslverr", {31'd0, e}, SLVERR_EXP);

        // RX threshold interrupt
        wr(0, A_THRESH, 32'h0000_0002);
        wr(0, A_CTRL, 32'h1);
        rd_chk(0, "thresh rb", A_THRESH, 32'h0000_0002);
        rd_chk(0, "ctrl rb", A_CTRL, 32'h1);
        rx_push(0, 32'h44);
        @(posedge pclk); #1;
        check("irq below th", {31'd0, irq0}, 32'd0);
        rx_push(0, 32'h55);
        check("irq th latency", {31'd0, irq0}, 32'd0);
        @(posedge pclk); #1;
        check("irq at th", {31'd0, irq0}, 32'd1);

        // Wait states on dut3
        rx_push(1, 32'h66);
        rx_push(1, 32'h77);
        apb(1, 1'b0, A_RXDATA, 32'd0, r, e, w);
        check("ws3 rd1 data", r, 32'h66);
        check("ws3 rd1 waits", w, 32'd3);
        rd_chk(1, "ws3 status", A_STATUS, 32'h0001_0002);
        apb(1, 1'b0, A_RXDATA, 32'd0, r, e, w);
        check("ws3 rd2 data", r, 32'h77);
        check("ws3 rd2 waits", w, 32'd3);
        apb(1, 1'b1, A_TXDATA, 32'hCAFE_0003, r, e, w);
        check("ws3 wr waits", w, 32'd3);
        check("ws3 wr pslverr", {31'd0, e}, 32'd0);
        rd_chk(1, "ws3 status after", A_STATUS, 32'h0000_0108);
        check("ws3 tx head", tx_data3, 32'hCAFE_0003);

        // Reset during the access phase of a TXDATA write on dut0
        @(posedge pclk); #1;
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_TXDATA; pwdata = 32'hBAD0_0001;
        @(posedge pclk); #1;
        penable = 1'b1; preset = 1'b1;
        @(negedge pclk);
        check("rstx pready", {31'd0, pready0}, 32'd1);
        check("rstx prdata", prdata0, 32'h0);
        check("rstx pslverr", {31'd0, pslverr0}, 32'd0);
        @(posedge pclk); #1;
        preset = 1'b0;
        @(negedge pclk);
        check("rstx tx_valid", {31'd0, tx_valid0}, 32'd0);
        check("rstx rx_ready", {31'd0, rx_ready0}, 32'd1);
        check("rstx irq", {31'd0, irq0}, 32'd0);
        check("rstx pready3", {31'd0, pready3}, 32'd0);
        @(posedge pclk); #1;
        psel0 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        rd_chk(0, "rstx status", A_STATUS, 32'h0000_000A);
        rd_chk(0, "rstx ctrl", A_CTRL, 32'h0);
        rd_chk(0, "rstx thresh", A_THRESH, 32'h0);
        rd_chk(0, "rstx intstat", A_INTSTAT, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
